spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-byte SPI master, mode 0 (sclk idles low, sample on
// rise, shift on fall). The sclk half-period is DIV clk cycles.
// Bit order: define SPI_LSB_FIRST_EN for LSB-first, otherwise MSB-first.
// Both builds have the same timing, FSM and ports.
// Every output is driven straight from a flop.
module spi_master_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss_n
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TC   = CW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    tx_sr_q, tx_sr_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          ss_n_q, ss_n_d;
  logic          tc_s, fall_s, last_fall_s;

  // The bit that goes out on the wire next is always the head of the TX register.
  function automatic logic tx_head(input logic [7:0] v);
`ifdef SPI_LSB_FIRST_EN
    return v[0];
`else
    return v[7];
`endif
  endfunction

  function automatic logic [7:0] tx_shift(input logic [7:0] v);
`ifdef SPI_LSB_FIRST_EN
    return {1'b0, v[7:1]};
`else
    return {v[6:0], 1'b0};
`endif
  endfunction

  // After 8 shifts, the first bit received sits at the far end of the register.
  function automatic logic [7:0] rx_shift(input logic [7:0] v, input logic b);
`ifdef SPI_LSB_FIRST_EN
    return {b, v[7:1]};
`else
    return {v[6:0], b};
`endif
  endfunction

  assign tc_s        = (div_cnt_q == CNT_TC);
  assign fall_s      = (state_q == S_SHIFT) && tc_s && sclk_q;
  assign last_fall_s = fall_s && (bit_cnt_q == 4'd7);

  // State, datapath and output flops; reset aborts any transfer immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= CNT_ZERO;
      bit_cnt_q <= 4'd0;
      tx_sr_q   <= 8'h00;
      rx_sr_q   <= 8'h00;
      rx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
    end
  end

  // Next-state logic: start is looked at only in IDLE, so it is never queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SETUP;
        else       state_d = S_IDLE;
      end
      S_SETUP: begin
        if (tc_s) state_d = S_SHIFT;
        else      state_d = S_SETUP;
      end
      S_SHIFT: begin
        if (last_fall_s) state_d = S_DONE;
        else             state_d = S_SHIFT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; the flags come from the next state so
  // they line up with it
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    ss_n_d    = (state_d == S_IDLE) || (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        div_cnt_d = CNT_ZERO;
        bit_cnt_d = 4'd0;
        sclk_d    = 1'b0;
        if (start) begin
          tx_sr_d = tx_data;
          rx_sr_d = 8'h00;
          mosi_d  = tx_head(tx_data);
        end else begin
          mosi_d  = 1'b0;
        end
      end
      S_SETUP: begin
        sclk_d = 1'b0;
        if (tc_s) div_cnt_d = CNT_ZERO;
        else      div_cnt_d = div_cnt_q + CNT_ONE;
      end
      S_SHIFT: begin
        if (tc_s) begin
          div_cnt_d = CNT_ZERO;
          sclk_d    = ~sclk_q;
          if (sclk_q) begin
            // Falling edge: advance TX and present the next bit
            tx_sr_d = tx_shift(tx_sr_q);
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              mosi_d    = 1'b0;
              rx_data_d = rx_sr_q;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              mosi_d    = tx_head(tx_shift(tx_sr_q));
            end
          end else begin
            // Rising edge: capture miso
            rx_sr_d = rx_shift(rx_sr_q, miso);
          end
        end else begin
          div_cnt_d = div_cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        div_cnt_d = CNT_ZERO;
        sclk_d    = 1'b0;
        mosi_d    = 1'b0;
      end
      default: begin
        div_cnt_d = CNT_ZERO;
        bit_cnt_d = 4'd0;
        sclk_d    = 1'b0;
        mosi_d    = 1'b0;
      end
    endcase
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: randomized checks of spi_master_ctrl (DIV=2) against a
// transaction-level model: wire bit order, completion cycle 17*DIV after
// acceptance, receive byte. The model follows SPI_LSB_FIRST_EN when defined.
module tb_spi_master_ctrl;

  localparam int DIV  = 2;
  localparam int XFER = 17 * DIV;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       ss_n;

  logic       loop_en;
  logic       miso_drv;
  int         vecs;
  int         miscompares;

  // What was observed during the most recent transfer
  int         obs_done_k;
  int         obs_done_n;
  int         obs_rises;
  logic [7:0] obs_wire;
  logic [7:0] obs_rx;
  logic       obs_busy_after;
  logic       obs_ss_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : miso_drv;

  spi_master_ctrl #(.DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .busy    (busy),
    .done    (done),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .ss_n    (ss_n)
  );

  // Model: w[j] is the j-th bit of byte b to appear on the wire
  function automatic logic [7:0] wire_order(input logic [7:0] b);
    logic [7:0] w;
    for (int j = 0; j < 8; j++) begin
`ifdef SPI_LSB_FIRST_EN
      w[j] = b[j];
`else
      w[j] = b[7 - j];
`endif
    end
    return w;
  endfunction

  // One transfer. The slave model drives pat onto miso in wire order
  // (loop=0), or miso follows mosi (loop=1). tx_data is scrambled after E0.
  task automatic do_transfer(input logic [7:0] tx, input logic loop, input logic [7:0] pat);
    logic [7:0] pat_w;
    logic       prev_sclk;
    pat_w = wire_order(pat);
    @(negedge clk);
    loop_en  = loop;
    miso_drv = pat_w[0];
    tx_data  = tx;
    start    = 1'b1;
    @(posedge clk);
    obs_done_k = -1; obs_done_n = 0; obs_rises = 0; obs_wire = 8'h00; obs_rx = 8'h00;
    obs_busy_after = 1'b1; obs_ss_bad = 1'b0; prev_sclk = 1'b0;
    for (int k = 0; k <= XFER + 1; k++) begin
      @(negedge clk);
      start   = 1'b0;
      tx_data = 8'($urandom);
      if (sclk && !prev_sclk) begin
        if (obs_rises < 8) obs_wire[obs_rises] = mosi;
        obs_rises++;
      end
      prev_sclk = sclk;
      miso_drv  = pat_w[(obs_rises < 8) ? obs_rises : 7];
      if (done) begin
        obs_done_n++;
        if (obs_done_k < 0) begin
          obs_done_k = k;
          obs_rx     = rx_data;
        end
      end
      if (k < XFER && ss_n) obs_ss_bad = 1'b1;
      if (k == XFER + 1) obs_busy_after = busy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    tx_data = 8'($urandom);
    repeat (3) @(negedge clk);
    vecs++; if (ss_n !== 1'b1)     begin miscompares++; $display("FAIL reset_ss_n: got %b expected 1", ss_n); end
    vecs++; if (sclk !== 1'b0)     begin miscompares++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    vecs++; if (mosi !== 1'b0)     begin miscompares++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    vecs++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vecs++; if (done !== 1'b0)     begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vecs++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %02h expected 00", rx_data); end
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [7:0] tx;
    for (int n = 0; n < 6; n++) begin
      tx = (n == 0) ? 8'hA5 : 8'($urandom);
      do_transfer(tx, 1'b1, 8'h00);
      vecs++; if (obs_done_k !== XFER) begin miscompares++; $display("FAIL loop_done_cycle tx=%02h: got %0d expected %0d", tx, obs_done_k, XFER); end
      vecs++; if (obs_done_n !== 1) begin miscompares++; $display("FAIL loop_done_width tx=%02h: got %0d expected 1", tx, obs_done_n); end
      vecs++; if (obs_rises !== 8) begin miscompares++; $display("FAIL loop_sclk_rises tx=%02h: got %0d expected 8", tx, obs_rises); end
      vecs++; if (obs_wire !== wire_order(tx)) begin miscompares++; $display("FAIL loop_mosi_bits tx=%02h: got %08b expected %08b", tx, obs_wire, wire_order(tx)); end
      vecs++; if (obs_rx !== tx) begin miscompares++; $display("FAIL loop_rx_data: got %02h expected %02h", obs_rx, tx); end
      vecs++; if (obs_busy_after !== 1'b0) begin miscompares++; $display("FAIL loop_busy_after tx=%02h: got %b expected 0", tx, obs_busy_after); end
      vecs++; if (obs_ss_bad !== 1'b0) begin miscompares++; $display("FAIL loop_ss_n_frame tx=%02h: got %b expected 0", tx, obs_ss_bad); end
    end
  endtask

  task automatic test_miso_pattern();
    logic [7:0] tx;
    logic [7:0] pat;
    for (int n = 0; n < 5; n++) begin
      tx  = (n == 0) ? 8'h3C : 8'($urandom);
      pat = (n == 0) ? 8'hFF : 8'($urandom);
      do_transfer(tx, 1'b0, pat);
      vecs++; if (obs_wire !== wire_order(tx)) begin miscompares++; $display("FAIL pat_mosi_bits tx=%02h: got %08b expected %08b", tx, obs_wire, wire_order(tx)); end
      vecs++; if (obs_rx !== pat) begin miscompares++; $display("FAIL pat_rx_data: got %02h expected %02h", obs_rx, pat); end
      vecs++; if (obs_done_k !== XFER) begin miscompares++; $display("FAIL pat_done_cycle: got %0d expected %0d", obs_done_k, XFER); end
      // rx_data must hold while idle even with miso wiggling
      repeat (4) begin
        @(negedge clk);
        miso_drv = ~miso_drv;
      end
      vecs++; if (rx_data !== pat) begin miscompares++; $display("FAIL pat_rx_hold: got %02h expected %02h", rx_data, pat); end
    end
  endtask

  task automatic test_start_held();
    int         first_k;
    int         second_k;
    int         n_done;
    int         hi_between;
    int         rises;
    logic       prev;
    logic [7:0] rx2;
    first_k = -1; second_k = -1; n_done = 0; hi_between = 0; rises = 0; prev = 1'b0; rx2 = 8'h00;
    @(negedge clk);
    loop_en = 1'b1;
    tx_data = 8'h11;
    start   = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2 * XFER + 6; k++) begin
      @(negedge clk);
      if (sclk && !prev) rises++;
      prev = sclk;
      if (done) begin
        n_done++;
        if (first_k < 0) begin
          first_k = k;
        end else if (second_k < 0) begin
          second_k = k;
          rx2      = rx_data;
          start    = 1'b0;
        end
      end
      if (first_k >= 0 && second_k < 0 && ss_n) hi_between++;
    end
    start = 1'b0;
    vecs++; if (first_k !== XFER) begin miscompares++; $display("FAIL held_first_done: got %0d expected %0d", first_k, XFER); end
    vecs++; if (second_k !== 2 * XFER + 2) begin miscompares++; $display("FAIL held_second_done: got %0d expected %0d", second_k, 2 * XFER + 2); end
    vecs++; if (n_done !== 2) begin miscompares++; $display("FAIL held_done_count: got %0d expected 2", n_done); end
    vecs++; if (hi_between !== 2) begin miscompares++; $display("FAIL held_ss_n_gap: got %0d expected 2", hi_between); end
    vecs++; if (rises !== 16) begin miscompares++; $display("FAIL held_sclk_rises: got %0d expected 16", rises); end
    vecs++; if (rx2 !== 8'h11) begin miscompares++; $display("FAIL held_rx_data: got %02h expected 11", rx2); end
    repeat (XFER + 4) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int   rises;
    logic prev;
    logic saw_done;
    rises = 0; prev = 1'b0; saw_done = 1'b0;
    @(negedge clk);
    loop_en = 1'b1;
    tx_data = 8'($urandom);
    start   = 1'b1;
    @(posedge clk);
    for (int k = 0; k < XFER && rises < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    start = 1'b0;
    vecs++; if (rises !== 3) begin miscompares++; $display("FAIL abort_third_rise: got %0d expected 3", rises); end
    #1 rst = 1'b0;
    #1;
    vecs++; if (ss_n !== 1'b1) begin miscompares++; $display("FAIL abort_ss_n: got %b expected 1", ss_n); end
    vecs++; if (sclk !== 1'b0) begin miscompares++; $display("FAIL abort_sclk: got %b expected 0", sclk); end
    vecs++; if ({busy, done, mosi, rx_data} !== 11'h000) begin miscompares++; $display("FAIL abort_outputs: got busy=%b done=%b mosi=%b rx=%02h expected all 0", busy, done, mosi, rx_data); end
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    vecs++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: got %b expected 0", saw_done); end
    vecs++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL abort_rx_zero: got %02h expected 00", rx_data); end
    do_transfer(8'h5A, 1'b1, 8'h00);
    vecs++; if (obs_rx !== 8'h5A) begin miscompares++; $display("FAIL after_abort_rx: got %02h expected 5a", obs_rx); end
    vecs++; if (obs_done_k !== XFER) begin miscompares++; $display("FAIL after_abort_done_cycle: got %0d expected %0d", obs_done_k, XFER); end
    vecs++; if (obs_rises !== 8) begin miscompares++; $display("FAIL after_abort_rises: got %0d expected 8", obs_rises); end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    tx_data     = 8'h00;
    loop_en     = 1'b1;
    miso_drv    = 1'b0;
    vecs        = 0;
    miscompares = 0;
    test_reset();
    test_loopback();
    test_miso_pattern();
    test_start_held();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
